// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller: per-module idle gating with wake handshake, plus a
// global RUN/DRAIN/SLEEP/RESUME sequencer driving the shared clock enable.
module clk_gate_ctrl #(
    parameter int unsigned NUM_MOD = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic               cpuclk,
    input  logic               cpurst_b,
    input  logic [NUM_MOD-1:0] mod_busy,
    input  logic [NUM_MOD-1:0] mod_wake_req,
    output logic [NUM_MOD-1:0] mod_wake_ack,
    input  logic [CNT_W-1:0]   idle_thresh,
    input  logic               sleep_req,
    input  logic               wake_irq,
    input  logic               pad_yy_test_mode,
    output logic [NUM_MOD-1:0] mod_clk_en,
    output logic               global_clk_en,
    output logic               sleep_ack,
    output logic [1:0]         ctrl_state
);

    typedef enum logic [1:0] {
        M_ON    = 2'd0,
        M_COUNT = 2'd1,
        M_OFF   = 2'd2,
        M_WAKE  = 2'd3
    } mod_st_t;

    typedef enum logic [1:0] {
        G_RUN    = 2'd0,
        G_DRAIN  = 2'd1,
        G_SLEEP  = 2'd2,
        G_RESUME = 2'd3
    } glb_st_t;

    mod_st_t          r_mst     [NUM_MOD];
    mod_st_t          w_mst_nxt [NUM_MOD];
    logic [CNT_W-1:0] r_cnt     [NUM_MOD];
    logic [CNT_W-1:0] w_cnt_nxt [NUM_MOD];
    glb_st_t          r_gst;
    glb_st_t          w_gst_nxt;
    logic             w_all_gated;

    // State registers
    always_ff @(posedge cpuclk) begin
        if (!cpurst_b) begin
            r_gst <= G_RUN;
            for (int i = 0; i < NUM_MOD; i++) begin
                r_mst[i] <= M_ON;
                r_cnt[i] <= '0;
            end
        end else begin
            r_gst <= w_gst_nxt;
            for (int i = 0; i < NUM_MOD; i++) begin
                r_mst[i] <= w_mst_nxt[i];
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    // A pending wake request counts as not gated so DRAIN cannot race a wake into SLEEP
    always_comb begin
        w_all_gated = 1'b1;
        for (int i = 0; i < NUM_MOD; i++) begin
            if (r_mst[i] != M_OFF || mod_wake_req[i]) begin
                w_all_gated = 1'b0;
            end
        end
    end

    // Per-module next state; all module FSMs are frozen while asleep
    always_comb begin
        for (int i = 0; i < NUM_MOD; i++) begin
            w_mst_nxt[i] = r_mst[i];
            w_cnt_nxt[i] = r_cnt[i];
            if (r_gst != G_SLEEP) begin
                case (r_mst[i])
                    M_ON: begin
                        if (!mod_busy[i] && !mod_wake_req[i]) begin
                            if (idle_thresh == '0) begin
                                w_mst_nxt[i] = M_OFF;
                            end else begin
                                w_mst_nxt[i] = M_COUNT;
                                w_cnt_nxt[i] = idle_thresh;
                            end
                        end
                    end
                    M_COUNT: begin
                        if (mod_busy[i] || mod_wake_req[i]) begin
                            w_mst_nxt[i] = M_ON;
                            w_cnt_nxt[i] = '0;
                        end else if (r_cnt[i] == CNT_W'(1)) begin
                            w_mst_nxt[i] = M_OFF;
                        end else begin
                            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
                        end
                    end
                    M_OFF: begin
                        if (mod_wake_req[i]) begin
                            w_mst_nxt[i] = M_WAKE;
                        end
                    end
                    default: begin
                        w_mst_nxt[i] = M_ON;
                    end
                endcase
            end
        end
    end

    // Global sequencer next state
    always_comb begin
        w_gst_nxt = r_gst;
        case (r_gst)
            G_RUN: begin
                if (sleep_req) begin
                    w_gst_nxt = G_DRAIN;
                end
            end
            G_DRAIN: begin
                if (!sleep_req) begin
                    w_gst_nxt = G_RUN;
                end else if (w_all_gated && !pad_yy_test_mode) begin
                    w_gst_nxt = G_SLEEP;
                end
            end
            G_SLEEP: begin
                if (wake_irq || !sleep_req || (|mod_wake_req)) begin
                    w_gst_nxt = G_RESUME;
                end
            end
            default: begin
                w_gst_nxt = G_RUN;
            end
        endcase
    end

    // Outputs decoded from registered state; test mode overrides enables only
    always_comb begin
        for (int i = 0; i < NUM_MOD; i++) begin
            mod_clk_en[i]   = (r_mst[i] != M_OFF) || pad_yy_test_mode;
            mod_wake_ack[i] = (r_mst[i] == M_WAKE);
        end
        global_clk_en = (r_gst != G_SLEEP) || pad_yy_test_mode;
        sleep_ack     = (r_gst == G_SLEEP);
        ctrl_state    = 2'(r_gst);
    end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameter NUM_MOD, default 4: number of gated module clock domains, legal range 1..16.
REQ-002 Parameter CNT_W, default 4: width of the idle threshold and idle counter.
REQ-003 cpuclk  in  1  single clock; all state updates on its rising edge.
REQ-004 cpurst_b  in  1  synchronous, active-low reset.
REQ-005 mod_busy  in  NUM_MOD  per-module activity; 1 = module needs its clock.
REQ-006 mod_wake_req  in  NUM_MOD  per-module wake request; held high by requester until mod_wake_ack.
REQ-007 mod_wake_ack  out  NUM_MOD  one-cycle pulse: module clock re-enabled.
REQ-008 idle_thresh  in  CNT_W  number of extra idle cycles tolerated before gating.
REQ-009 sleep_req  in  1  level request for whole-block sleep.
REQ-010 wake_irq  in  1  level wake event that terminates sleep.
REQ-011 pad_yy_test_mode  in  1  scan/test mode; forces all clocks on.
REQ-012 mod_clk_en  out  NUM_MOD  per-module enable, drives module_en of a gated clock cell.
REQ-013 global_clk_en  out  1  drives global_en of all gated clock cells.
REQ-014 sleep_ack  out  1  level; 1 only while global state is SLEEP.
REQ-015 ctrl_state  out  2  global state: RUN=0, DRAIN=1, SLEEP=2, RESUME=3.

Function
REQ-016 Each module i has an independent FSM: ON, COUNT, OFF, WAKE, plus a CNT_W-bit counter.
REQ-017 ON: mod_clk_en[i]=1; if mod_busy[i]=0 and mod_wake_req[i]=0 -> COUNT with counter loaded from idle_thresh, except idle_thresh=0 -> OFF directly.
REQ-018 COUNT: mod_clk_en[i]=1; mod_busy[i] or mod_wake_req[i] high -> ON (counter cleared); else if counter=1 -> OFF; else counter decrements by 1.
REQ-019 Net effect: idle_thresh+1 consecutive idle samples -> mod_clk_en[i]=0 from the next cycle; idle_thresh is sampled only on ON->COUNT entry.
REQ-020 OFF: mod_clk_en[i]=0; mod_busy[i] ignored; mod_wake_req[i]=1 and global state not SLEEP -> WAKE.
REQ-021 WAKE: mod_clk_en[i]=1, mod_wake_ack[i]=1 for exactly this one cycle; next state ON unconditionally.
REQ-022 Wake latency: request sampled in OFF -> enable and ack high on the next cycle.
REQ-023 Global FSM RUN: global_clk_en=1; sleep_req=1 -> DRAIN.
REQ-024 DRAIN: global_clk_en=1; sleep_req=0 -> RUN; else all module FSMs in OFF and pad_yy_test_mode=0 -> SLEEP; else hold.
REQ-025 SLEEP: global_clk_en=0, sleep_ack=1; wake_irq=1, sleep_req=0, or any mod_wake_req bit =1 -> RESUME; module FSMs frozen in OFF.
REQ-026 RESUME: global_clk_en=1, sleep_ack=0, one cycle, then RUN; pending mod_wake_req proceeds OFF->WAKE in RESUME.
REQ-027 Simultaneous wake_irq and sleep_req in SLEEP: wake_irq wins -> RESUME; sleep_req still high in RUN re-enters DRAIN next cycle.
REQ-028 In DRAIN, module wakes are permitted; a woken module blocks DRAIN->SLEEP until it gates again.
REQ-029 pad_yy_test_mode=1 forces mod_clk_en all ones and global_clk_en=1 combinationally; FSMs keep running; mod_wake_ack unaffected.
REQ-030 All outputs except the test-mode override are registered or decoded from registered state only.

Reset
REQ-031 cpurst_b=0 at a rising edge -> next cycle: all module FSMs ON, counters 0, mod_clk_en all ones, mod_wake_ack 0, global RUN, global_clk_en=1, sleep_ack=0, ctrl_state=0.
REQ-032 Reset asserted mid-operation (COUNT, WAKE, DRAIN, SLEEP) aborts it identically; no ack pulse is emitted after reset.

Verification
REQ-033 idle_thresh=3, mod_busy[0] falls at cycle 10 and stays low -> mod_clk_en[0]=0 from cycle 14; busy re-asserted at cycle 12 -> enable never drops.
REQ-034 idle_thresh=0, module 1 idle one cycle -> gated next cycle; mod_wake_req[1] raised at cycle 20 -> mod_clk_en[1]=1 and mod_wake_ack[1]=1 at cycle 21, ack 0 at cycle 22.
REQ-035 sleep_req=1 with module 2 busy -> ctrl_state=1 held; module 2 gates -> ctrl_state=2, global_clk_en=0, sleep_ack=1 next cycle.
REQ-036 In SLEEP, wake_irq and sleep_req both high -> ctrl_state 3 then 0 then 1; global_clk_en=1 throughout.
REQ-037 pad_yy_test_mode=1 during DRAIN with all modules OFF -> all enables 1, ctrl_state stays 1.
REQ-038 cpurst_b=0 for one cycle while in SLEEP -> next cycle all reset values of REQ-031.
